// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - command-driven LED sequencer (OFF/ON/BLINK/BURST) timed in ticks
`timescale 1ns/1ps
module led_seq_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NLED    = 2,
  parameter int TW      = 16
) (
  input  logic            sysClk,
  input  logic            rstN,
  input  logic            cmdValid,
  output logic            cmdReady,
  input  logic [1:0]      cmdMode,
  input  logic [NLED-1:0] cmdMask,
  input  logic [TW-1:0]   cmdOnT,
  input  logic [TW-1:0]   cmdOffT,
  input  logic [TW-1:0]   cmdCount,
  output logic [NLED-1:0] led,
  output logic            busy,
  output logic            burstDone
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    BLINK_ON,
    BLINK_OFF,
    BURST_ON,
    BURST_OFF
  } state_t;

  state_t          state, stateNxt;
  logic [PW-1:0]   presc;
  logic [NLED-1:0] mask, maskNxt, ledNxt;
  logic [TW-1:0]   onT, offT, count;
  logic [TW-1:0]   phCnt, phCntNxt;
  logic [TW-1:0]   pulseCnt, pulseCntNxt;
  logic [TW:0]     phLen, phCntInc, pulseCntInc;
  logic            accept, tick, phEnd;
  logic            busyNxt, doneNxt, readyNxt;

  assign accept = cmdValid && cmdReady;
  assign tick   = (presc == PRESC_MAX);

  always_comb begin
    stateNxt    = state;
    phCntNxt    = phCnt;
    pulseCntNxt = pulseCnt;
    doneNxt     = 1'b0;
    maskNxt     = accept ? cmdMask : mask;

    // A programmed duration of 0 behaves as a single tick.
    phLen = {1'b0, offT};
    if (state == BLINK_ON || state == BURST_ON) begin
      phLen = {1'b0, onT};
    end
    if (phLen == '0) begin
      phLen = (TW+1)'(1);
    end
    phCntInc    = {1'b0, phCnt} + (TW+1)'(1);
    pulseCntInc = {1'b0, pulseCnt} + (TW+1)'(1);
    phEnd       = tick && (phCntInc >= phLen);

    if (accept) begin
      phCntNxt    = '0;
      pulseCntNxt = '0;
      case (cmdMode)
        MODE_OFF:   stateNxt = IDLE;
        MODE_ON:    stateNxt = HOLD;
        MODE_BLINK: stateNxt = BLINK_ON;
        MODE_BURST: begin
          if (cmdCount == '0) begin
            stateNxt = IDLE;
            doneNxt  = 1'b1;
          end else begin
            stateNxt = BURST_ON;
          end
        end
        default:    stateNxt = IDLE;
      endcase
    end else if (tick && (state == BLINK_ON || state == BLINK_OFF ||
                          state == BURST_ON || state == BURST_OFF)) begin
      if (phEnd) begin
        phCntNxt = '0;
        case (state)
          BLINK_ON:  stateNxt = BLINK_OFF;
          BLINK_OFF: stateNxt = BLINK_ON;
          BURST_ON:  stateNxt = BURST_OFF;
          BURST_OFF: begin
            pulseCntNxt = pulseCntInc[TW-1:0];
            if (pulseCntInc == {1'b0, count}) begin
              stateNxt = IDLE;
              doneNxt  = 1'b1;
            end else begin
              stateNxt = BURST_ON;
            end
          end
          default:   stateNxt = state;
        endcase
      end else if (!phCntInc[TW]) begin
        phCntNxt = phCntInc[TW-1:0];
      end
    end

    ledNxt = '0;
    if (stateNxt == HOLD || stateNxt == BLINK_ON || stateNxt == BURST_ON) begin
      ledNxt = maskNxt;
    end
    busyNxt  = (stateNxt == BLINK_ON) || (stateNxt == BLINK_OFF) ||
               (stateNxt == BURST_ON) || (stateNxt == BURST_OFF);
    readyNxt = !((stateNxt == BURST_ON) || (stateNxt == BURST_OFF));
  end

  always_ff @(posedge sysClk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      presc     <= '0;
      mask      <= '0;
      onT       <= '0;
      offT      <= '0;
      count     <= '0;
      phCnt     <= '0;
      pulseCnt  <= '0;
      led       <= '0;
      busy      <= 1'b0;
      burstDone <= 1'b0;
      cmdReady  <= 1'b0;
    end else begin
      state     <= stateNxt;
      phCnt     <= phCntNxt;
      pulseCnt  <= pulseCntNxt;
      led       <= ledNxt;
      busy      <= busyNxt;
      burstDone <= doneNxt;
      cmdReady  <= readyNxt;
      // Restarting the prescaler on accept makes the first tick land DIV cycles later.
      if (accept || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
      if (accept) begin
        mask  <= cmdMask;
        onT   <= cmdOnT;
        offT  <= cmdOffT;
        count <= cmdCount;
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - randomized bench for led_seq_ctrl against a timeline model
`timescale 1ns/1ps
module tb_led_seq_ctrl;

  localparam int DIV = 10;

  logic        sysClk = 1'b0;
  logic        rstN = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [1:0]  cmdMode = 2'd0;
  logic [1:0]  cmdMask = 2'd0;
  logic [15:0] cmdOnT = 16'd0;
  logic [15:0] cmdOffT = 16'd0;
  logic [15:0] cmdCount = 16'd0;
  logic [1:0]  led;
  logic        busy;
  logic        burstDone;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the last accepted command plus cycles elapsed since its accepting edge.
  int       m_mode = 0;
  logic [1:0] m_mask = 2'b00;
  int       m_on = 1;
  int       m_off = 1;
  int       m_cnt = 0;
  int       m_t = 0;
  bit       m_fresh = 1'b1;

  led_seq_ctrl #(
    .CLK_HZ(1000), .TICK_HZ(100), .NLED(2), .TW(16)
  ) dut (
    .sysClk(sysClk), .rstN(rstN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdMode(cmdMode), .cmdMask(cmdMask), .cmdOnT(cmdOnT), .cmdOffT(cmdOffT),
    .cmdCount(cmdCount), .led(led), .busy(busy), .burstDone(burstDone)
  );

  always #5 sysClk = ~sysClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int span(input int v);
    return ((v == 0) ? 1 : v) * DIV;
  endfunction

  function automatic bit m_ready();
    int per;
    per = span(m_on) + span(m_off);
    if (m_fresh) return 1'b0;
    if (m_mode == 3 && m_cnt > 0 && m_t < m_cnt * per) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all();
    int on_s, per;
    logic [1:0] el;
    logic eb, ed;
    on_s = span(m_on);
    per  = on_s + span(m_off);
    el = 2'b00; eb = 1'b0; ed = 1'b0;
    case (m_mode)
      1: el = m_mask;
      2: begin
        eb = 1'b1;
        el = ((m_t % per) < on_s) ? m_mask : 2'b00;
      end
      3: begin
        if (m_cnt == 0) begin
          ed = (m_t == 0);
        end else if (m_t < m_cnt * per) begin
          eb = 1'b1;
          el = ((m_t % per) < on_s) ? m_mask : 2'b00;
        end else begin
          ed = (m_t == m_cnt * per);
        end
      end
      default: el = 2'b00;
    endcase
    chk("led", 32'(led), 32'(el));
    chk("busy", 32'(busy), 32'(eb));
    chk("burstDone", 32'(burstDone), 32'(ed));
    chk("cmdReady", 32'(cmdReady), 32'(m_ready()));
  endtask

  task automatic cycle(output bit acc);
    @(posedge sysClk);
    acc = rstN && cmdValid && m_ready();
    if (!rstN) begin
      m_fresh = 1'b1;
      m_mode  = 0;
    end else begin
      if (acc) begin
        m_mode = int'(cmdMode);
        m_mask = cmdMask;
        m_on   = int'(cmdOnT);
        m_off  = int'(cmdOffT);
        m_cnt  = int'(cmdCount);
        m_t    = 0;
      end else if (m_t < (1 << 30)) begin
        m_t++;
      end
      m_fresh = 1'b0;
    end
    @(negedge sysClk);
    check_all();
  endtask

  task automatic run(input int n);
    bit a;
    repeat (n) cycle(a);
  endtask

  task automatic send(input int mode, input int mask, input int on, input int off, input int cnt);
    bit a;
    int k;
    a = 1'b0;
    k = 0;
    cmdMode  = 2'(mode);
    cmdMask  = 2'(mask);
    cmdOnT   = 16'(on);
    cmdOffT  = 16'(off);
    cmdCount = 16'(cnt);
    cmdValid = 1'b1;
    while (!a && k < 2000) begin
      cycle(a);
      k++;
    end
    cmdValid = 1'b0;
    if (!a) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout got=no-accept exp=accept at %0t", $time);
    end
  endtask

  initial begin
    run(3);
    rstN = 1'b1;
    run(2);

    send(1, 1, 0, 0, 0);
    run(500);

    send(2, 3, 2, 3, 0);
    run(120);

    send(3, 2, 1, 1, 3);
    send(0, 0, 0, 0, 0);
    run(20);

    send(2, 3, 1, 2, 0);
    run(17);
    send(1, 1, 0, 0, 0);
    run(20);

    send(3, 3, 1, 1, 0);
    run(10);

    send(2, 2, 0, 0, 0);
    run(60);

    send(3, 3, 5, 5, 4);
    run(25);
    #2 rstN = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    m_fresh = 1'b1;
    m_mode  = 0;
    run(3);
    rstN = 1'b1;
    run(150);

    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
           int'($urandom_range(0, 3)));
      run(int'($urandom_range(0, 120)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
